// File: rtl/seq_tx_1011_if.sv
// -----------------------------------------------------------------------------
// seq_tx_1011_if
// Payload handshake bundle for seq_tx_1011.
//   data_i  : parallel payload (DATA_W bits), MSB transmitted first
//   valid_i : payload offered by the producer
//   ready_o : transmitter can accept a payload this cycle
// Modports:
//   master : producer side (drives data_i/valid_i, observes ready_o)
//   slave  : transmitter side (observes data_i/valid_i, drives ready_o)
// -----------------------------------------------------------------------------
interface seq_tx_1011_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;

  modport master (
    output data_i,
    output valid_i,
    input  ready_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o
  );
endinterface

// File: rtl/seq_tx_1011.sv
// -----------------------------------------------------------------------------
// seq_tx_1011
// Serial frame transmitter. Each accepted payload is sent as a frame:
//   header 1,0,1,1 | DATA_W payload bits MSB first | [even parity bit]
// followed by GAP forced idle '0' bits. Every output is registered.
//
// Parameters:
//   DATA_W : payload bits per frame (1..32)
//   GAP    : idle '0' bits forced after each frame (0..15)
//
// Ports:
//   clk     : sole clock, rising edge
//   rstn    : asynchronous active-low reset
//   bus     : payload handshake (seq_tx_1011_if.slave: data_i, valid_i, ready_o)
//   out     : serial bit stream, one bit per clock
//   sof_o   : high while the first header bit is on out
//   done_o  : high while the last frame bit is on out
//
// Build option:
//   SEQ_TX_PARITY_EN : when defined, one even-parity bit (XOR of the payload)
//                      follows the payload LSB and done_o marks that bit.
// -----------------------------------------------------------------------------
module seq_tx_1011 #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned GAP    = 1
) (
  input  logic             clk,
  input  logic             rstn,
  seq_tx_1011_if.slave     bus,
  output logic             out,
  output logic             sof_o,
  output logic             done_o
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [3:0]       GAP_LOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
`ifdef SEQ_TX_PARITY_EN
  localparam bit               PAR_EN   = 1'b1;
`else
  localparam bit               PAR_EN   = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
`ifdef SEQ_TX_PARITY_EN
    S_PAR,
`endif
    S_GAP
  } state_t;

  // The state names what is currently on 'out'; next-state logic also
  // computes the next output values so every output comes from a flop.
  state_t              r_state, w_state;
  logic [1:0]          r_hcnt,  w_hcnt;   // header bit index on out
  logic [CNT_W-1:0]    r_cnt,   w_cnt;    // payload bits still to send after the one on out
  logic [3:0]          r_gcnt,  w_gcnt;   // gap cycles still to go after the current one
  logic [DATA_W-1:0]   r_shift, w_shift;
  logic                r_out,   w_out;
  logic                r_sof,   w_sof;
  logic                r_done,  w_done;
  logic                r_ready, w_ready;
  logic                w_frame_end;
`ifdef SEQ_TX_PARITY_EN
  logic                r_par,   w_par;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_shift <= '0;
      r_out   <= 1'b0;
      r_sof   <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_hcnt  <= w_hcnt;
      r_cnt   <= w_cnt;
      r_gcnt  <= w_gcnt;
      r_shift <= w_shift;
      r_out   <= w_out;
      r_sof   <= w_sof;
      r_done  <= w_done;
      r_ready <= w_ready;
`ifdef SEQ_TX_PARITY_EN
      r_par   <= w_par;
`endif
    end
  end

  always_comb begin
    w_state     = r_state;
    w_hcnt      = r_hcnt;
    w_cnt       = r_cnt;
    w_gcnt      = r_gcnt;
    w_shift     = r_shift;
    w_out       = 1'b0;
    w_sof       = 1'b0;
    w_done      = 1'b0;
    w_ready     = 1'b0;
    w_frame_end = 1'b0;
`ifdef SEQ_TX_PARITY_EN
    w_par       = r_par;
`endif

    case (r_state)
      S_IDLE: begin
        // r_ready is low on the first edge after reset, so that edge only
        // raises ready and never accepts.
        if (r_ready && bus.valid_i) begin
          w_state = S_HDR;
          w_hcnt  = 2'd0;
          w_shift = bus.data_i;
          w_out   = 1'b1;
          w_sof   = 1'b1;
`ifdef SEQ_TX_PARITY_EN
          w_par   = ^bus.data_i;
`endif
        end else begin
          w_ready = 1'b1;
        end
      end

      S_HDR: begin
        if (r_hcnt != 2'd3) begin
          // Header 1,0,1,1: the bit after index 0 is the only zero.
          w_hcnt = r_hcnt + 2'd1;
          w_out  = (r_hcnt != 2'd0);
        end else begin
          w_state = S_DATA;
          w_out   = r_shift[DATA_W-1];
          w_shift = r_shift << 1;
          w_cnt   = LAST_CNT;
          w_done  = !PAR_EN && (LAST_CNT == '0);
        end
      end

      S_DATA: begin
        if (r_cnt != '0) begin
          w_out   = r_shift[DATA_W-1];
          w_shift = r_shift << 1;
          w_cnt   = r_cnt - CNT_W'(1);
          w_done  = !PAR_EN && (r_cnt == CNT_W'(1));
        end else begin
`ifdef SEQ_TX_PARITY_EN
          w_state = S_PAR;
          w_out   = r_par;
          w_done  = 1'b1;
`else
          w_frame_end = 1'b1;
`endif
        end
      end

`ifdef SEQ_TX_PARITY_EN
      S_PAR: begin
        w_frame_end = 1'b1;
      end
`endif

      S_GAP: begin
        if (r_gcnt != 4'd0) begin
          w_gcnt = r_gcnt - 4'd1;
        end else begin
          w_state = S_IDLE;
          w_ready = 1'b1;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Shared exit after the final frame bit: GAP zeros, or straight to IDLE.
    if (w_frame_end) begin
      if (GAP != 0) begin
        w_state = S_GAP;
        w_gcnt  = GAP_LOAD;
      end else begin
        w_state = S_IDLE;
        w_ready = 1'b1;
      end
    end
  end

  assign out         = r_out;
  assign sof_o       = r_sof;
  assign done_o      = r_done;
  assign bus.ready_o = r_ready;

endmodule

// File: doc/seq_tx_1011.md
SEQ_TX_1011 -- requirements
Module: seq_tx_1011

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame (legal 1..32).
REQ-002 SHALL have parameter GAP, default 1, idle '0' bits forced after each frame (legal 0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port data_i  input  DATA_W  parallel payload, MSB transmitted first.
REQ-006 SHALL have port valid_i  input  1  payload offered.
REQ-007 SHALL have port ready_o  output  1  block can accept a payload this cycle.
REQ-008 SHALL have port out  output  1  serial bit stream, one bit per clk.
REQ-009 SHALL have port sof_o  output  1  high while first header bit is on out.
REQ-010 SHALL have port done_o  output  1  high while last frame bit (payload LSB, or parity) is on out.

Function
REQ-011 SHALL implement FSM states IDLE, HDR, DATA, PAR, GAP; all outputs registered.
REQ-012 SHALL accept a payload when valid_i and ready_o are both high at a rising edge; data_i captured into a shift register in that edge.
REQ-013 SHALL drive ready_o high only in IDLE; data_i/valid_i ignored in all other states.
REQ-014 SHALL in IDLE drive out=0; on accept, move to HDR.
REQ-015 SHALL in HDR drive out = 1,0,1,1 on four consecutive cycles, first bit in the cycle after accept, sof_o high with the first bit only.
REQ-016 SHALL in DATA drive DATA_W payload bits MSB first, one per cycle, tracked by a $clog2(DATA_W+1)-bit counter.
REQ-017 SHALL after the last payload bit enter PAR (macro defined) or GAP/IDLE (macro undefined).
REQ-018 SHALL in GAP drive out=0 for exactly GAP cycles with ready_o low, then enter IDLE; GAP=0 SHALL go directly to IDLE.
REQ-019 SHALL produce frame length 4+DATA_W(+1 parity) bits; minimum accept-to-accept period 1+4+DATA_W(+1)+GAP cycles.
REQ-020 SHALL hold captured payload stable if data_i changes mid-frame.
REQ-021 SHALL pulse done_o for exactly one cycle per frame, coincident with the final frame bit.
REQ-022 SHALL never drive out high in IDLE or GAP.

Reset
REQ-023 SHALL on rstn low immediately (asynchronously) force state IDLE, out=0, sof_o=0, done_o=0, ready_o=0, counter and shift register 0.
REQ-024 SHALL raise ready_o on the first rising edge after rstn deasserts.
REQ-025 SHALL abandon a frame in progress on reset; no partial bits resume after release.

Configuration
REQ-026 SHALL honour macro SEQ_TX_PARITY_EN: defined -> PAR state appends one even-parity bit (XOR of payload) after the payload LSB, done_o on that bit; undefined -> no PAR state, done_o on payload LSB.

Verification
REQ-027 SHALL cover: DATA_W=8, GAP=1, accept 0xA5 at cycle 0 -> out cycles 1..12 = 1011 10100101, cycle 13 = 0, ready_o high cycle 14; sof_o cycle 1, done_o cycle 12.
REQ-028 SHALL cover: SEQ_TX_PARITY_EN defined, payload 0x07 -> parity bit 1 at cycle 13, done_o cycle 13; payload 0xA5 -> parity bit 0.
REQ-029 SHALL cover: valid_i held high with 0x0F then 0xF0 -> two back-to-back frames separated by GAP zeros plus one IDLE cycle, second frame = 1011 11110000.
REQ-030 SHALL cover: rstn pulsed low during DATA bit 3 -> out=0 and ready_o=0 asynchronously, ready_o=1 one edge after release, no further header/payload bits until next accept.
REQ-031 SHALL cover: GAP=0, valid_i toggled and data_i changed mid-frame -> transmitted payload equals value at accept, ready_o high the cycle right after done_o.
